mmss_display: RTL and testbench

Time-keeping and display stage for the Basys3 digital clock, directly downstream of the clock divider. It consumes the divider's square-wave `divided_clk` in the `clk` domain and edge-detects it into a scan/count tick. It keeps an MM:SS time in BCD and drives the 4-digit multiplexed seven-segment display (`an`/`seg`/`dp`).

---
 rtl/mmss_pkg.sv | 61 ++++++
 rtl/seg7_decode.sv | 28 ++
 rtl/mmss_display.sv | 184 ++++++++++++++++++
 tb/tb_mmss_display.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mmss_pkg.sv
// mmss_pkg: shared types, constants and helpers for the MM:SS display stage.
//   bcd_t           - one BCD digit (4 bits)
//   SEG_0..SEG_9    - active-low seven-segment patterns, bit order {g,f,e,d,c,b,a}
//   SEG_BLANK       - all segments off
//   AN_OFF          - all digit enables off
//   bcd_pair_next   - increment a tens/ones pair that counts 00..59
//   bcd_pair_at_max - true when a tens/ones pair holds 59
//   an_select       - active-low one-hot digit enable for a 2-bit index
package mmss_pkg;

    typedef logic [3:0] bcd_t;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [3:0] AN_OFF    = 4'b1111;

    // Next value of a 00..59 pair; 59 wraps to 00 (carry reported separately).
    function automatic logic [7:0] bcd_pair_next(input bcd_t tens, input bcd_t ones);
        bcd_t t;
        bcd_t o;
        t = tens;
        o = ones;
        if (ones >= 4'd9) begin
            o = 4'd0;
            if (tens >= 4'd5) begin
                t = 4'd0;
            end else begin
                t = tens + 4'd1;
            end
        end else begin
            o = ones + 4'd1;
        end
        return {t, o};
    endfunction

    function automatic logic bcd_pair_at_max(input bcd_t tens, input bcd_t ones);
        return (tens >= 4'd5) && (ones >= 4'd9);
    endfunction

    function automatic logic [3:0] an_select(input logic [1:0] idx);
        logic [3:0] an_v;
        case (idx)
            2'd0:    an_v = 4'b1110;
            2'd1:    an_v = 4'b1101;
            2'd2:    an_v = 4'b1011;
            2'd3:    an_v = 4'b0111;
            default: an_v = AN_OFF;
        endcase
        return an_v;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: combinational BCD to active-low seven-segment decoder.
//   bcd in  4 - digit value; anything above 9 blanks the digit
//   seg out 7 - active-low segments, seg[0]=a .. seg[6]=g
module seg7_decode
    import mmss_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    // Pattern lookup; non-BCD codes light nothing.
    always_comb begin
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/mmss_display.sv
// mmss_display: MM:SS time keeping and 4-digit multiplexed seven-segment drive.
// Optional feature macro: COLON_BLINK_EN (decimal point on digit 2 acts as colon).
//   TICKS_PER_SEC    - rising edges of divided_clk per second
//   clk         in 1 - board clock
//   rst_n       in 1 - synchronous active-low reset
//   divided_clk in 1 - divider square wave, same clock domain as clk
//   run         in 1 - 1: time advances, 0: time frozen (scan keeps going)
//   inc_sec     in 1 - one-cycle pulse, seconds +1 (no carry into minutes)
//   inc_min     in 1 - one-cycle pulse, minutes +1
//   an         out 4 - active-low digit enables, an[0] = rightmost
//   seg        out 7 - active-low segments, seg[0]=a .. seg[6]=g
//   dp         out 1 - active-low decimal point
//   sec_tick   out 1 - one-cycle pulse per automatic second advance
module mmss_display
    import mmss_pkg::*;
#(
    parameter int TICKS_PER_SEC = 2000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       divided_clk,
    input  logic       run,
    input  logic       inc_sec,
    input  logic       inc_min,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       sec_tick
);

    localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);

    logic          prev_r;
    logic [PW-1:0] presc_r;
    logic [1:0]    idx_r;
    bcd_t          sec_ones_r, sec_tens_r, min_ones_r, min_tens_r;
    logic          sec_tick_r;
    logic [3:0]    an_r;
    logic [6:0]    seg_r;
    logic          dp_r;

    logic          tick_s;
    logic          inc_any_s;
    logic          wrap_s;
    logic [7:0]    sec_pair_s;
    logic [7:0]    min_pair_s;
    logic [PW-1:0] presc_nx_s;
    bcd_t          sec_ones_nx_s, sec_tens_nx_s, min_ones_nx_s, min_tens_nx_s;
    bcd_t          sel_digit_s;
    logic [6:0]    dec_seg_s;
    logic          dp_nx_s;

    assign tick_s     = divided_clk & ~prev_r;
    assign inc_any_s  = inc_sec | inc_min;
    // A manual increment wins over the terminal tick: no automatic advance then.
    assign wrap_s     = tick_s & run & ~inc_any_s & (presc_r == PRESC_LAST);
    assign sec_pair_s = bcd_pair_next(sec_tens_r, sec_ones_r);
    assign min_pair_s = bcd_pair_next(min_tens_r, min_ones_r);

    // Next prescaler value: cleared by any manual increment, else counts run ticks.
    always_comb begin
        presc_nx_s = presc_r;
        if (inc_any_s) begin
            presc_nx_s = {PW{1'b0}};
        end else if (tick_s & run) begin
            if (presc_r == PRESC_LAST) begin
                presc_nx_s = {PW{1'b0}};
            end else begin
                presc_nx_s = presc_r + PW'(1);
            end
        end else begin
            presc_nx_s = presc_r;
        end
    end

    // Next time value; the full seconds-to-minutes carry resolves in one cycle.
    always_comb begin
        sec_ones_nx_s = sec_ones_r;
        sec_tens_nx_s = sec_tens_r;
        min_ones_nx_s = min_ones_r;
        min_tens_nx_s = min_tens_r;
        if (inc_any_s) begin
            if (inc_sec) begin
                {sec_tens_nx_s, sec_ones_nx_s} = sec_pair_s;
            end else begin
                {sec_tens_nx_s, sec_ones_nx_s} = {sec_tens_r, sec_ones_r};
            end
            if (inc_min) begin
                {min_tens_nx_s, min_ones_nx_s} = min_pair_s;
            end else begin
                {min_tens_nx_s, min_ones_nx_s} = {min_tens_r, min_ones_r};
            end
        end else if (wrap_s) begin
            {sec_tens_nx_s, sec_ones_nx_s} = sec_pair_s;
            if (bcd_pair_at_max(sec_tens_r, sec_ones_r)) begin
                {min_tens_nx_s, min_ones_nx_s} = min_pair_s;
            end else begin
                {min_tens_nx_s, min_ones_nx_s} = {min_tens_r, min_ones_r};
            end
        end else begin
            {sec_tens_nx_s, sec_ones_nx_s} = {sec_tens_r, sec_ones_r};
            {min_tens_nx_s, min_ones_nx_s} = {min_tens_r, min_ones_r};
        end
    end

    // Digit multiplexer feeding the shared decoder.
    always_comb begin
        case (idx_r)
            2'd0:    sel_digit_s = sec_ones_r;
            2'd1:    sel_digit_s = sec_tens_r;
            2'd2:    sel_digit_s = min_ones_r;
            2'd3:    sel_digit_s = min_tens_r;
            default: sel_digit_s = sec_ones_r;
        endcase
    end

    seg7_decode u_decode (
        .bcd (sel_digit_s),
        .seg (dec_seg_s)
    );

`ifdef COLON_BLINK_EN
    localparam logic [PW-1:0] PRESC_HALF = PW'(TICKS_PER_SEC / 2);

    // Colon on digit 2: blinks with the first half-second while running, steady when frozen.
    always_comb begin
        dp_nx_s = 1'b1;
        if (idx_r == 2'd2) begin
            if (run) begin
                dp_nx_s = (presc_r < PRESC_HALF) ? 1'b0 : 1'b1;
            end else begin
                dp_nx_s = 1'b0;
            end
        end else begin
            dp_nx_s = 1'b1;
        end
    end
`else
    assign dp_nx_s = 1'b1;
`endif

    // Counting state: edge detector, prescaler, scan index, time and second pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev_r     <= 1'b1;
            presc_r    <= {PW{1'b0}};
            idx_r      <= 2'd0;
            sec_ones_r <= 4'd0;
            sec_tens_r <= 4'd0;
            min_ones_r <= 4'd0;
            min_tens_r <= 4'd0;
            sec_tick_r <= 1'b0;
        end else begin
            prev_r     <= divided_clk;
            presc_r    <= presc_nx_s;
            idx_r      <= tick_s ? (idx_r + 2'd1) : idx_r;
            sec_ones_r <= sec_ones_nx_s;
            sec_tens_r <= sec_tens_nx_s;
            min_ones_r <= min_ones_nx_s;
            min_tens_r <= min_tens_nx_s;
            sec_tick_r <= wrap_s;
        end
    end

    // Display registers: one cycle behind the index and time they show.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            an_r  <= AN_OFF;
            seg_r <= SEG_BLANK;
            dp_r  <= 1'b1;
        end else begin
            an_r  <= an_select(idx_r);
            seg_r <= dec_seg_s;
            dp_r  <= dp_nx_s;
        end
    end

    assign an       = an_r;
    assign seg      = seg_r;
    assign dp       = dp_r;
    assign sec_tick = sec_tick_r;

endmodule

// File: tb/tb_mmss_display.sv
// tb_mmss_display: self-checking bench for mmss_display with TICKS_PER_SEC = 4.
// A time model (total seconds 0..3599) predicts an/seg/dp/sec_tick every cycle;
// directed steps add literal expectations for the notable scenarios.
module tb_mmss_display;

    localparam int T = 4;
`ifdef COLON_BLINK_EN
    localparam bit BLINK = 1'b1;
`else
    localparam bit BLINK = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n, divided_clk, run, inc_sec, inc_min;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp, sec_tick;

    int total = 0;
    int bad   = 0;
    int stick_cnt = 0;
    int base;

    mmss_display #(.TICKS_PER_SEC(T)) dut (
        .clk(clk), .rst_n(rst_n), .divided_clk(divided_clk), .run(run),
        .inc_sec(inc_sec), .inc_min(inc_min),
        .an(an), .seg(seg), .dp(dp), .sec_tick(sec_tick)
    );

    always #5 clk = ~clk;

    logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                 7'b0000000, 7'b0010000};
    logic [3:0] an_seq [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    // Model state: time as total seconds, prescaler count, digit index.
    int         m_secs = 0, m_presc = 0, m_idx = 0;
    bit         m_prev = 1'b1;
    logic [3:0] e_an = 4'hF;
    logic [6:0] e_seg = 7'h7F;
    logic       e_dp = 1'b1, e_stick = 1'b0;

    function automatic int digit_of(int s, int i);
        int sc = s % 60;
        int mn = s / 60;
        case (i)
            0:       return sc % 10;
            1:       return sc / 10;
            2:       return mn % 10;
            default: return mn / 10;
        endcase
    endfunction

    function automatic int next_secs(int s, int p, bit tk, bit r, bit is, bit im);
        int sc = s % 60;
        int mn = s / 60;
        if (is || im) begin
            if (is) sc = (sc + 1) % 60;
            if (im) mn = (mn + 1) % 60;
            return mn * 60 + sc;
        end
        if (tk && r && p == T - 1) return (s + 1) % 3600;
        return s;
    endfunction

    function automatic int next_presc(int p, bit tk, bit r, bit is, bit im);
        if (is || im) return 0;
        if (tk && r) return (p + 1) % T;
        return p;
    endfunction

    function automatic bit exp_dp(int i, int p, bit r);
        if (!BLINK || i != 2) return 1'b1;
        if (!r) return 1'b0;
        return (p < T / 2) ? 1'b0 : 1'b1;
    endfunction

    // Model step on each clock edge.
    always @(posedge clk) begin
        if (!rst_n) begin
            m_secs <= 0; m_presc <= 0; m_idx <= 0; m_prev <= 1'b1;
            e_an <= 4'hF; e_seg <= 7'h7F; e_dp <= 1'b1; e_stick <= 1'b0;
        end else begin
            e_an    <= ~(4'b0001 << m_idx);
            e_seg   <= seg_tab[digit_of(m_secs, m_idx)];
            e_dp    <= exp_dp(m_idx, m_presc, run);
            e_stick <= (divided_clk && !m_prev) && run && !inc_sec && !inc_min && (m_presc == T - 1);
            m_secs  <= next_secs(m_secs, m_presc, divided_clk && !m_prev, run, inc_sec, inc_min);
            m_presc <= next_presc(m_presc, divided_clk && !m_prev, run, inc_sec, inc_min);
            m_idx   <= (divided_clk && !m_prev) ? (m_idx + 1) % 4 : m_idx;
            m_prev  <= divided_clk;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, just after the active edge.
    always @(posedge clk) begin
        #1;
        check("an", {28'd0, an}, {28'd0, e_an});
        check("seg", {25'd0, seg}, {25'd0, e_seg});
        check("dp", {31'd0, dp}, {31'd0, e_dp});
        check("sec_tick", {31'd0, sec_tick}, {31'd0, e_stick});
    end

    // Second-pulse counter.
    always @(posedge clk) begin
        #1;
        if (sec_tick === 1'b1) stick_cnt <= stick_cnt + 1;
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic edge_pulse();
        divided_clk = 1'b1;
        @(negedge clk);
        divided_clk = 1'b0;
        @(negedge clk);
    endtask

    task automatic pulse_sec();
        inc_sec = 1'b1;
        @(negedge clk);
        inc_sec = 1'b0;
        @(negedge clk);
    endtask

    task automatic pulse_min();
        inc_min = 1'b1;
        @(negedge clk);
        inc_min = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; divided_clk = 1'b1; run = 1'b0; inc_sec = 1'b0; inc_min = 1'b0;
        cycles(3);
        check("rst_an", {28'd0, an}, 32'h0000000F);
        check("rst_seg", {25'd0, seg}, 32'h0000007F);
        check("rst_dp", {31'd0, dp}, 32'd1);
        check("rst_sec_tick", {31'd0, sec_tick}, 32'd0);

        // Release with divided_clk high: no spurious tick.
        rst_n = 1'b1;
        cycles(1);
        check("first_an", {28'd0, an}, {28'd0, 4'b1110});
        check("first_seg", {25'd0, seg}, {25'd0, 7'b1000000});
        cycles(1);
        check("no_spurious_tick", {28'd0, an}, {28'd0, 4'b1110});
        divided_clk = 1'b0;
        cycles(1);

        // One second of ticks.
        run = 1'b1;
        base = stick_cnt;
        repeat (4) edge_pulse();
        check("one_sec_pulses", stick_cnt - base, 32'd1);
        check("one_sec_an", {28'd0, an}, {28'd0, 4'b1110});
        check("one_sec_seg", {25'd0, seg}, {25'd0, 7'b1111001});

        // Reset mid-count.
        edge_pulse();
        rst_n = 1'b0;
        cycles(1);
        check("midrst_an", {28'd0, an}, 32'h0000000F);
        check("midrst_seg", {25'd0, seg}, 32'h0000007F);
        rst_n = 1'b1;
        run = 1'b0;
        cycles(1);
        check("midrst_rel_seg", {25'd0, seg}, {25'd0, 7'b1000000});

        // Set 59:59 and roll over.
        repeat (59) pulse_min();
        repeat (59) pulse_sec();
        check("model_5959", m_secs, 32'd3599);
        check("d0_nine", {25'd0, seg}, {25'd0, 7'b0010000});
        repeat (3) edge_pulse();
        check("d3_an", {28'd0, an}, {28'd0, 4'b0111});
        check("d3_five", {25'd0, seg}, {25'd0, 7'b0010010});
        edge_pulse();
        run = 1'b1;
        base = stick_cnt;
        repeat (4) edge_pulse();
        check("wrap_pulses", stick_cnt - base, 32'd1);
        check("model_0000", m_secs, 32'd0);
        check("wrap_d0", {25'd0, seg}, {25'd0, 7'b1000000});
        run = 1'b0;
        for (int k = 1; k < 4; k++) begin
            edge_pulse();
            check("wrap_scan_an", {28'd0, an}, {28'd0, an_seq[k]});
            check("wrap_scan_seg", {25'd0, seg}, {25'd0, 7'b1000000});
        end
        edge_pulse();

        // inc_sec collides with the terminal tick.
        run = 1'b1;
        base = stick_cnt;
        repeat (3) edge_pulse();
        check("pre_term_pulses", stick_cnt - base, 32'd0);
        divided_clk = 1'b1; inc_sec = 1'b1;
        @(negedge clk);
        divided_clk = 1'b0; inc_sec = 1'b0;
        @(negedge clk);
        check("collide_pulses", stick_cnt - base, 32'd0);
        check("collide_presc", m_presc, 32'd0);
        check("collide_seg", {25'd0, seg}, {25'd0, 7'b1111001});
        repeat (3) edge_pulse();
        check("post_collide_3", stick_cnt - base, 32'd0);
        edge_pulse();
        check("post_collide_4", stick_cnt - base, 32'd1);
        check("two_sec_seg", {25'd0, seg}, {25'd0, 7'b0100100});

        // Frozen time, scan continues.
        run = 1'b0;
        base = stick_cnt;
        for (int k = 0; k < 10; k++) begin
            check("frozen_scan_an", {28'd0, an}, {28'd0, an_seq[k % 4]});
            edge_pulse();
        end
        check("frozen_pulses", stick_cnt - base, 32'd0);
        check("frozen_time", m_secs, 32'd2);

        // Colon phase on digit 2 for each prescaler value.
        run = 1'b1;
        for (int t = 0; t < 4; t++) begin
            for (int g = 0; g < 4 && m_idx != ((6 - t) % 4); g++) edge_pulse();
            pulse_sec();
            repeat (t) edge_pulse();
            check("colon_an", {28'd0, an}, {28'd0, 4'b1011});
            check("colon_dp", {31'd0, dp}, (BLINK && t < 2) ? 32'd0 : 32'd1);
        end

        cycles(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
